exp_norm_m: RTL and testbench

- Downstream of the multiplier's exponent add/subtract stage.
- Captures the registered biased-exponent sum (Ea+Eb, EW+1 bits) together with that stage's overflow/underflow flags and the mantissa product's MSB.
- Removes the bias, applies the +1 normalization increment, and produces the final EW-bit exponent and final flags.
- Presents the result through a valid/ack handshake to the packing/rounding stage.

---
 rtl/mult_exp_pkg.sv | 22 ++
 rtl/exp_range_check_m.sv | 32 +++
 rtl/exp_norm_m.sv | 142 ++++++++++++++
 tb/tb_exp_norm_m.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_exp_pkg.sv
// Shared types and constants for the multiplier exponent normalization stage.
package mult_exp_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      BIAS  = 3'd1,
      NORM  = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4
   } state_e;

   // IEEE exponent bias: 127 for EW=8, 1023 for EW=11
   function automatic int unsigned bias_f(input int unsigned ew);
      return (32'd1 << (ew - 32'd1)) - 32'd1;
   endfunction

   // All-ones biased exponent, reserved for Inf/NaN
   function automatic int unsigned exp_max_f(input int unsigned ew);
      return (32'd1 << ew) - 32'd1;
   endfunction

endpackage

// File: rtl/exp_range_check_m.sv
// Combinational range check of the normalized exponent: derives the final
// overflow/underflow conditions and the saturated EW-bit exponent.
module exp_range_check_m
   import mult_exp_pkg::*;
#(
   parameter int unsigned EW = 8
) (
   input  logic signed [EW+1:0] i_e2,
   input  logic                 i_ovf_in,
   input  logic                 i_unf_in,
   output logic                 o_ovf_c,
   output logic                 o_unf_c,
   output logic [EW-1:0]        o_exp_c
);

   localparam logic signed [EW+1:0] EXP_MAX = (EW+2)'(exp_max_f(EW));
   localparam logic signed [EW+1:0] ZERO    = '0;

   assign o_ovf_c = i_ovf_in | (i_e2 >= EXP_MAX);
   assign o_unf_c = i_unf_in | (i_e2 <= ZERO);

   // Overflow saturates to all ones ahead of underflow flushing to zero
   always_comb begin
      o_exp_c = i_e2[EW-1:0];
      if (o_ovf_c) begin
         o_exp_c = '1;
      end else if (o_unf_c) begin
         o_exp_c = '0;
      end
   end

endmodule

// File: rtl/exp_norm_m.sv
// Exponent normalization stage: unbias, +1 normalize, range check, valid/ack out.
// Optional sticky overflow/underflow flags under EXP_NORM_STICKY_FLAGS_EN.
module exp_norm_m
   import mult_exp_pkg::*;
#(
   parameter int unsigned EW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_i,
   input  logic [EW:0]   exp_sum_i,
   input  logic          ovf_in_i,
   input  logic          unf_in_i,
   input  logic          mant_msb_i,
   input  logic          ack_i,
`ifdef EXP_NORM_STICKY_FLAGS_EN
   input  logic          clr_sticky_i,
   output logic          sticky_ovf_o,
   output logic          sticky_unf_o,
`endif
   output logic [EW-1:0] exp_o,
   output logic          overflow_o,
   output logic          underflow_o,
   output logic          valid_o,
   output logic          busy_o
);

   localparam int unsigned   EW2    = EW + 2;
   localparam logic [EW+1:0] BIAS_V = EW2'(bias_f(EW));

   state_e                r_state;
   state_e                w_state_nxt;
   logic [EW:0]           r_exp_sum;
   logic                  r_ovf_in;
   logic                  r_unf_in;
   logic                  r_mant_msb;
   logic signed [EW+1:0]  r_e;
   logic [EW-1:0]         r_exp;
   logic                  r_overflow;
   logic                  r_underflow;
   logic                  r_valid;
   logic                  r_busy;
   logic                  w_ovf;
   logic                  w_unf;
   logic [EW-1:0]         w_exp;

   exp_range_check_m #(.EW(EW)) u_range_check (
      .i_e2     (r_e),
      .i_ovf_in (r_ovf_in),
      .i_unf_in (r_unf_in),
      .o_ovf_c  (w_ovf),
      .o_unf_c  (w_unf),
      .o_exp_c  (w_exp)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // start_i is only honoured in IDLE; ack_i only in DONE
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start_i) w_state_nxt = BIAS;
         BIAS:    w_state_nxt = NORM;
         NORM:    w_state_nxt = CHECK;
         CHECK:   w_state_nxt = DONE;
         DONE:    if (ack_i) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_exp_sum   <= '0;
         r_ovf_in    <= 1'b0;
         r_unf_in    <= 1'b0;
         r_mant_msb  <= 1'b0;
         r_e         <= '0;
         r_exp       <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         r_valid     <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_valid <= (w_state_nxt == DONE);
         r_busy  <= (w_state_nxt != IDLE);
         case (r_state)
            IDLE: begin
               if (start_i) begin
                  r_exp_sum  <= exp_sum_i;
                  r_ovf_in   <= ovf_in_i;
                  r_unf_in   <= unf_in_i;
                  r_mant_msb <= mant_msb_i;
               end
            end
            // EW+2 bits keep the full sum range minus bias from wrapping
            BIAS:  r_e <= $signed({1'b0, r_exp_sum} - BIAS_V);
            NORM:  r_e <= r_e + $signed({{(EW+1){1'b0}}, r_mant_msb});
            CHECK: begin
               r_exp       <= w_exp;
               r_overflow  <= w_ovf;
               r_underflow <= w_unf & ~w_ovf;
            end
            default: ;
         endcase
      end
   end

`ifdef EXP_NORM_STICKY_FLAGS_EN
   logic r_sticky_ovf;
   logic r_sticky_unf;

   // Set on the transition into DONE; a simultaneous clear loses to the set
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sticky_ovf <= 1'b0;
         r_sticky_unf <= 1'b0;
      end else if (r_state == CHECK) begin
         r_sticky_ovf <= w_ovf | (r_sticky_ovf & ~clr_sticky_i);
         r_sticky_unf <= (w_unf & ~w_ovf) | (r_sticky_unf & ~clr_sticky_i);
      end else if (clr_sticky_i) begin
         r_sticky_ovf <= 1'b0;
         r_sticky_unf <= 1'b0;
      end
   end

   assign sticky_ovf_o = r_sticky_ovf;
   assign sticky_unf_o = r_sticky_unf;
`endif

   assign exp_o       = r_exp;
   assign overflow_o  = r_overflow;
   assign underflow_o = r_underflow;
   assign valid_o     = r_valid;
   assign busy_o      = r_busy;

endmodule

// File: tb/tb_exp_norm_m.sv
// Randomized self-checking bench for exp_norm_m (EW=8) against an arithmetic model.
module tb_exp_norm_m;

   localparam int unsigned EW = 8;

   logic          clk;
   logic          rst;
   logic          start_i;
   logic [EW:0]   exp_sum_i;
   logic          ovf_in_i;
   logic          unf_in_i;
   logic          mant_msb_i;
   logic          ack_i;
   logic [EW-1:0] exp_o;
   logic          overflow_o;
   logic          underflow_o;
   logic          valid_o;
   logic          busy_o;
`ifdef EXP_NORM_STICKY_FLAGS_EN
   logic          clr_sticky_i;
   logic          sticky_ovf_o;
   logic          sticky_unf_o;
`endif

   int n_checks;
   int n_fail;
   bit m_sovf;
   bit m_sunf;

   exp_norm_m #(.EW(EW)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .exp_sum_i    (exp_sum_i),
      .ovf_in_i     (ovf_in_i),
      .unf_in_i     (unf_in_i),
      .mant_msb_i   (mant_msb_i),
      .ack_i        (ack_i),
`ifdef EXP_NORM_STICKY_FLAGS_EN
      .clr_sticky_i (clr_sticky_i),
      .sticky_ovf_o (sticky_ovf_o),
      .sticky_unf_o (sticky_unf_o),
`endif
      .exp_o        (exp_o),
      .overflow_o   (overflow_o),
      .underflow_o  (underflow_o),
      .valid_o      (valid_o),
      .busy_o       (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One operation: start, latency check, optional ack stall with ignored
   // start pulses, then ack and post-ack hold checks.
   task automatic run_op(input int sum, input bit fo, input bit fu, input bit msb,
                         input int hold, input bit inj, input bit clr);
      int e2;
      int ee;
      int lat;
      bit eo;
      bit eu;
      e2 = sum - 127 + int'(msb);
      eo = fo || (e2 >= 255);
      eu = !eo && (fu || (e2 <= 0));
      ee = eo ? 255 : (eu ? 0 : e2);
      if (clr) begin
         m_sovf = 1'b0;
         m_sunf = 1'b0;
      end
      m_sovf = m_sovf | eo;
      m_sunf = m_sunf | eu;

      exp_sum_i  = 9'(sum);
      ovf_in_i   = fo;
      unf_in_i   = fu;
      mant_msb_i = msb;
      start_i    = 1'b1;
      @(negedge clk);
      start_i = inj;
      if (inj) begin
         exp_sum_i  = ~exp_sum_i;
         ovf_in_i   = ~fo;
         mant_msb_i = ~msb;
      end
      check_eq("busy_in_op", 32'(busy_o), 1);
      lat = 1;
      while (!valid_o && lat < 20) begin
`ifdef EXP_NORM_STICKY_FLAGS_EN
         clr_sticky_i = clr && (lat == 3);
`endif
         @(negedge clk);
         start_i = 1'b0;
         lat++;
      end
`ifdef EXP_NORM_STICKY_FLAGS_EN
      clr_sticky_i = 1'b0;
`endif
      check_eq("latency", lat, 4);
      check_eq("exp", 32'(exp_o), ee);
      check_eq("overflow", 32'(overflow_o), 32'(eo));
      check_eq("underflow", 32'(underflow_o), 32'(eu));
`ifdef EXP_NORM_STICKY_FLAGS_EN
      check_eq("sticky_ovf", 32'(sticky_ovf_o), 32'(m_sovf));
      check_eq("sticky_unf", 32'(sticky_unf_o), 32'(m_sunf));
`endif
      for (int i = 0; i < hold; i++) begin
         start_i   = inj && (i == 0);
         exp_sum_i = 9'($urandom_range(0, 511));
         @(negedge clk);
         start_i = 1'b0;
         check_eq("hold_valid", 32'(valid_o), 1);
         check_eq("hold_exp", 32'(exp_o), ee);
         check_eq("hold_ovf", 32'(overflow_o), 32'(eo));
      end
      ack_i = 1'b1;
      @(negedge clk);
      ack_i = 1'b0;
      check_eq("ack_valid", 32'(valid_o), 0);
      check_eq("ack_busy", 32'(busy_o), 0);
      check_eq("ack_exp_held", 32'(exp_o), ee);
      check_eq("ack_unf_held", 32'(underflow_o), 32'(eu));
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      m_sovf     = 1'b0;
      m_sunf     = 1'b0;
      rst        = 1'b1;
      start_i    = 1'b0;
      exp_sum_i  = '0;
      ovf_in_i   = 1'b0;
      unf_in_i   = 1'b0;
      mant_msb_i = 1'b0;
      ack_i      = 1'b0;
`ifdef EXP_NORM_STICKY_FLAGS_EN
      clr_sticky_i = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check_eq("rst_exp", 32'(exp_o), 0);
      check_eq("rst_valid", 32'(valid_o), 0);
      check_eq("rst_busy", 32'(busy_o), 0);
      check_eq("rst_ovf", 32'(overflow_o), 0);
      rst = 1'b0;
      @(negedge clk);

      // ack with nothing valid is harmless
      ack_i = 1'b1;
      @(negedge clk);
      ack_i = 1'b0;
      check_eq("idle_ack_valid", 32'(valid_o), 0);
      check_eq("idle_ack_busy", 32'(busy_o), 0);

      run_op(254, 0, 0, 0, 3, 0, 0);
      run_op(380, 0, 0, 1, 0, 0, 0);
      run_op(381, 0, 0, 0, 0, 0, 0);
      run_op(381, 0, 0, 1, 1, 0, 0);
      run_op(254, 0, 0, 0, 0, 0, 0);
      run_op(127, 0, 0, 0, 0, 0, 1);
      run_op(127, 0, 0, 1, 0, 0, 0);
      run_op(254, 1, 1, 0, 0, 0, 0);
      run_op(0,   0, 0, 0, 0, 0, 0);
      run_op(510, 0, 0, 1, 0, 0, 0);
      run_op(200, 0, 0, 1, 2, 1, 0);

      // Reset in NORM with a previous non-zero result still on the outputs
      run_op(380, 0, 0, 1, 0, 0, 0);
      exp_sum_i = 9'd127;
      start_i   = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("arst_exp", 32'(exp_o), 0);
      check_eq("arst_busy", 32'(busy_o), 0);
      check_eq("arst_valid", 32'(valid_o), 0);
      check_eq("arst_ovf", 32'(overflow_o), 0);
      check_eq("arst_unf", 32'(underflow_o), 0);
      m_sovf = 1'b0;
      m_sunf = 1'b0;
`ifdef EXP_NORM_STICKY_FLAGS_EN
      check_eq("arst_sticky_ovf", 32'(sticky_ovf_o), 0);
`endif
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("post_rst_busy", 32'(busy_o), 0);
      run_op(300, 0, 0, 0, 0, 0, 0);

      for (int k = 0; k < 40; k++) begin
         int h;
         h = int'($urandom_range(0, 3));
         run_op(int'($urandom_range(0, 511)),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 1)),
                h,
                (h > 0) && ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 5) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
